// File: rtl/jtcps1_fetch_arb.sv
// Read-only SDRAM arbiter for the CPS1 video fetch path: three VRAM and three GFX ROM
// readers, each with a one-entry address/data cache. Optional macro JTCPS1_ARB_ROMPRIO_EN.
module jtcps1_fetch_arb #(
    parameter logic [21:0] VRAM_OFFSET = 22'h32_0000,
    parameter logic [21:0] GFX_OFFSET  = 22'h10_0000,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [2:0]  vram_cs,
    input  logic [53:0] vram_addr,
    output logic [47:0] vram_data,
    output logic [2:0]  vram_ok,
    input  logic [2:0]  rom_cs,
    input  logic [65:0] rom_addr,
    output logic [95:0] rom_data,
    output logic [2:0]  rom_ok,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic [21:0] sdram_addr,
    input  logic        data_rdy,
    input  logic [31:0] data_read,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    localparam logic [5:0] WAIT_LAST = 6'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [21:0] slot_addr  [6];
    logic [21:0] slot_off   [6];
    logic [21:0] cache_addr [6];
    logic [15:0] vcache     [3];
    logic [31:0] rcache     [3];
    logic [5:0]  cs, valid, hit, pend;
    logic [2:0]  cur_slot;
    logic [1:0]  rom_idx;
    logic [21:0] cur_addr;
    logic [5:0]  wcnt;
    logic        discard;
    logic        found, grant, wait_done;
    logic [2:0]  sel;
`ifdef JTCPS1_ARB_ROMPRIO_EN
    logic [1:0]  vptr, rptr;
`else
    logic [2:0]  rr_ptr;
`endif

    assign cs = {rom_cs, vram_cs};

    for (genvar g = 0; g < 3; g++) begin : g_slot
        assign slot_addr[g]           = {4'd0, vram_addr[18*g +: 18]};
        assign slot_addr[g+3]         = rom_addr[22*g +: 22];
        assign slot_off[g]            = VRAM_OFFSET;
        assign slot_off[g+3]          = GFX_OFFSET;
        assign vram_data[16*g +: 16]  = vcache[g];
        assign rom_data[32*g +: 32]   = rcache[g];
    end

    for (genvar g = 0; g < 6; g++) begin : g_hit
        assign hit[g]  = cs[g] && valid[g] && (slot_addr[g] == cache_addr[g]);
        assign pend[g] = cs[g] && !hit[g];
    end

    assign vram_ok = hit[2:0] & {3{~downloading}};
    assign rom_ok  = hit[5:3] & {3{~downloading}};
    assign rom_idx = 2'(cur_slot - 3'd3);

    // Round-robin search starting at the slot after the last grant
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
`ifdef JTCPS1_ARB_ROMPRIO_EN
        for (int unsigned k = 0; k < 3; k++) begin
            logic [2:0] ri;
            ri = {1'b0, rptr} + 3'(k);
            if (ri >= 3'd3) ri = ri - 3'd3;
            if (!found && pend[ri + 3'd3]) begin
                found = 1'b1;
                sel   = ri + 3'd3;
            end
        end
        for (int unsigned k = 0; k < 3; k++) begin
            logic [2:0] vi;
            vi = {1'b0, vptr} + 3'(k);
            if (vi >= 3'd3) vi = vi - 3'd3;
            if (!found && pend[vi]) begin
                found = 1'b1;
                sel   = vi;
            end
        end
`else
        for (int unsigned k = 0; k < 6; k++) begin
            logic [3:0] idx;
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'd6) idx = idx - 4'd6;
            if (!found && pend[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
`endif
    end

    assign grant     = (state_q == IDLE) && !downloading && found;
    assign wait_done = data_rdy || (wcnt == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (grant)     state_d = WAIT_ACK;
            WAIT_ACK:  if (sdram_ack) state_d = WAIT_DATA;
            WAIT_DATA: if (wait_done) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid       <= '0;
            sdram_req   <= 1'b0;
            sdram_addr  <= '0;
            timeout_err <= 1'b0;
            cur_slot    <= '0;
            cur_addr    <= '0;
            wcnt        <= '0;
            discard     <= 1'b0;
`ifdef JTCPS1_ARB_ROMPRIO_EN
            vptr        <= '0;
            rptr        <= '0;
`else
            rr_ptr      <= '0;
`endif
            for (int unsigned i = 0; i < 6; i++) cache_addr[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                vcache[i] <= '0;
                rcache[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (downloading) valid <= '0;
            unique case (state_q)
                IDLE: if (grant) begin
                    cur_slot   <= sel;
                    cur_addr   <= slot_addr[sel];
                    sdram_addr <= slot_off[sel] + slot_addr[sel];
                    sdram_req  <= 1'b1;
                    discard    <= 1'b0;
`ifdef JTCPS1_ARB_ROMPRIO_EN
                    if (sel >= 3'd3) rptr <= (sel == 3'd5) ? 2'd0 : 2'(sel - 3'd2);
                    else             vptr <= (sel == 3'd2) ? 2'd0 : 2'(sel + 3'd1);
`else
                    rr_ptr <= (sel == 3'd5) ? 3'd0 : sel + 3'd1;
`endif
                end
                WAIT_ACK: begin
                    if (downloading) discard <= 1'b1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        wcnt      <= '0;
                    end
                end
                WAIT_DATA: begin
                    if (downloading) discard <= 1'b1;
                    if (data_rdy) begin
                        // A download seen at any point during the fetch voids the result
                        if (!discard && !downloading) begin
                            valid[cur_slot]      <= 1'b1;
                            cache_addr[cur_slot] <= cur_addr;
                            if (cur_slot < 3'd3) vcache[cur_slot[1:0]] <= data_read[15:0];
                            else                 rcache[rom_idx]       <= data_read;
                        end
                    end else if (wcnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps1_fetch_arb.sv
// Self-checking bench for jtcps1_fetch_arb: directed scenarios plus randomized traffic
// compared against a slot-level cache/arbitration model.
module tb_jtcps1_fetch_arb;

    localparam logic [21:0] VOFF = 22'h32_0000;
    localparam logic [21:0] GOFF = 22'h10_0000;
    localparam int          TMO  = 64;

    logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0;
    logic [2:0]  vram_cs = '0, rom_cs = '0;
    logic [53:0] vram_addr = '0;
    logic [65:0] rom_addr = '0;
    logic [47:0] vram_data;
    logic [95:0] rom_data;
    logic [2:0]  vram_ok, rom_ok;
    logic        sdram_req, timeout_err;
    logic        sdram_ack = 1'b0, data_rdy = 1'b0;
    logic [21:0] sdram_addr;
    logic [31:0] data_read = '0;

    int checks = 0, errors = 0;

    bit          m_valid [6];
    logic [21:0] m_addr  [6];
    logic [31:0] m_data  [6];
    int          m_last, m_last_v, m_last_r;

    jtcps1_fetch_arb #(.VRAM_OFFSET(VOFF), .GFX_OFFSET(GOFF), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .vram_cs(vram_cs), .vram_addr(vram_addr), .vram_data(vram_data), .vram_ok(vram_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
        .data_rdy(data_rdy), .data_read(data_read), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] taddr(input int s);
        if (s < 3) return {4'd0, vram_addr[18*s +: 18]};
        return rom_addr[22*(s-3) +: 22];
    endfunction

    function automatic bit tcs(input int s);
        return (s < 3) ? vram_cs[s] : rom_cs[s-3];
    endfunction

    function automatic bit m_hit(input int s);
        return tcs(s) && m_valid[s] && (m_addr[s] == taddr(s));
    endfunction

    function automatic int predict();
`ifdef JTCPS1_ARB_ROMPRIO_EN
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = 3 + (m_last_r - 3 + k) % 3;
            if (tcs(s) && !m_hit(s)) return s;
        end
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (m_last_v + k) % 3;
            if (tcs(s) && !m_hit(s)) return s;
        end
`else
        for (int k = 1; k <= 6; k++) begin
            int s;
            s = (m_last + k) % 6;
            if (tcs(s) && !m_hit(s)) return s;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_valid[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        end
        m_last = 5; m_last_v = 2; m_last_r = 5;
    endtask

    task automatic set_dl(input logic v);
        downloading = v;
        if (v) for (int i = 0; i < 6; i++) m_valid[i] = 0;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 6; i++) begin
            logic        eok, aok;
            logic [31:0] ad, ed;
            eok = !downloading && m_hit(i);
            aok = (i < 3) ? vram_ok[i] : rom_ok[i-3];
            ad  = (i < 3) ? {16'd0, vram_data[16*i +: 16]} : rom_data[32*(i-3) +: 32];
            ed  = (i < 3) ? {16'd0, m_data[i][15:0]} : m_data[i];
            chk($sformatf("%s ok slot%0d", tag, i), aok, eok);
            chk($sformatf("%s data slot%0d", tag, i), ad, ed);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; vram_cs = '0; rom_cs = '0; set_dl(1'b0);
        repeat (3) @(negedge clk);
        #1;
        model_reset();
        chk("reset sdram_req", sdram_req, 0);
        chk("reset sdram_addr", sdram_addr, 0);
        chk("reset timeout_err", timeout_err, 0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Acts as the SDRAM controller for one transaction and checks the slot chosen.
    task automatic fetch(input int ack_dly, input int data_dly, input bit give,
                         input bit dl_mid, input logic [31:0] d);
        int s, n;
        logic [21:0] la, ea;
        s  = predict();
        if (s < 0) s = 0;
        la = taddr(s);
        ea = ((s < 3) ? VOFF : GOFF) + la;
        n  = 0;
        while (!sdram_req && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("req rise", sdram_req, 1);
        chk($sformatf("sdram_addr slot%0d", s), sdram_addr, ea);
        m_last = s;
        if (s >= 3) m_last_r = s; else m_last_v = s;
        repeat (ack_dly) @(negedge clk);
        #1 chk("req hold", {sdram_req, sdram_addr}, {1'b1, ea});
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        if (dl_mid) set_dl(1'b1);
        #1 chk("req drop", sdram_req, 0);
        if (give) begin
            repeat (data_dly - 1) @(negedge clk);
            data_read = d; data_rdy = 1'b1;
            #1 check_outputs("pre-store");
            @(negedge clk);
            data_rdy = 1'b0;
            if (!downloading) begin
                m_valid[s] = 1; m_addr[s] = la; m_data[s] = d;
            end
            #1 check_outputs("post-store");
        end else begin
            repeat (TMO - 1) @(negedge clk);
            #1 chk("timeout not yet", {sdram_req, timeout_err}, 0);
            @(negedge clk);
            #1 chk("timeout flag", timeout_err, 1);
            check_outputs("after timeout");
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Miss then hit on VRAM slot 0
        vram_addr[17:0] = 18'h00100;
        vram_cs = 3'b001;
        fetch(1, 3, 1, 0, 32'hBEEF_1234);
        chk("vram0 data", vram_data[15:0], 16'h1234);
        repeat (3) begin
            @(negedge clk); #1;
            chk("hit no req", sdram_req, 0);
            check_outputs("hit");
        end
        vram_cs = 3'b000;
        #1 chk("cs low ok", vram_ok[0], 0);
        @(negedge clk);
        vram_cs = 3'b001;
        #1 chk("re-assert hit", vram_ok[0], 1);
        // Stray strobes while idle must be ignored
        data_rdy = 1'b1; sdram_ack = 1'b1; data_read = $urandom;
        @(negedge clk);
        data_rdy = 1'b0; sdram_ack = 1'b0;
        #1 chk("stray strobe req", sdram_req, 0);
        check_outputs("stray strobe");

        // Round-robin across all six slots, then two re-pends
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vram_addr[18*i +: 18] = 18'(32'h200 + i);
            rom_addr[22*i +: 22]  = 22'(32'h3000 + i);
        end
        vram_cs = 3'b111; rom_cs = 3'b111;
        repeat (6) fetch(3, 3, 1, 0, $urandom);
        rom_addr[22*1 +: 22]  = 22'h3_5555;
        vram_addr[18*1 +: 18] = 18'h2_AAAA;
        repeat (2) fetch(3, 3, 1, 0, $urandom);

        // ROM path
        vram_cs = '0; rom_cs = 3'b100;
        rom_addr[22*2 +: 22] = 22'h00_0040;
        fetch(1, 2, 1, 0, 32'hCAFE_F00D);
        chk("rom5 data", rom_data[95:64], 32'hCAFE_F00D);

        // Timeout, then the slot re-requests
        rom_addr[22*2 +: 22] = 22'h00_0041;
        fetch(1, 0, 0, 0, '0);
        fetch(1, 2, 1, 0, $urandom);
        chk("timeout sticky", timeout_err, 1);

        // Download during WAIT_DATA
        rom_addr[22*2 +: 22] = 22'h00_0040;
        vram_addr[17:0] = 18'h00500; vram_cs = 3'b001;
        fetch(1, 3, 1, 1, $urandom);
        repeat (4) begin
            @(negedge clk); #1;
            chk("dl no req", sdram_req, 0);
            check_outputs("dl high");
        end
        @(negedge clk);
        set_dl(1'b0);
        repeat (2) fetch(1, 2, 1, 0, $urandom);

        // VRAM and ROM pending together
        vram_cs = 3'b001; rom_cs = 3'b001;
        vram_addr[17:0] = 18'h00777; rom_addr[21:0] = 22'h2_0777;
        @(negedge clk);
        repeat (2) fetch(1, 2, 1, 0, $urandom);

        // Randomized traffic
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            vram_cs = 3'($urandom); rom_cs = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                vram_addr[18*i +: 18] = 18'($urandom_range(0, 3) + 32'h100 * i);
                rom_addr[22*i +: 22]  = 22'h3F_FFFE + 22'($urandom_range(0, 3));
            end
            #1 check_outputs("rand");
            for (int g = 0; g < 8 && predict() >= 0; g++)
                fetch($urandom_range(0, 3), $urandom_range(1, 4), 1, 0, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtcps1_fetch_arb.md
Name: jtcps1_fetch_arb

Overview:
- Read-only SDRAM arbiter for the CPS1 video fetch path.
- Shares one SDRAM request/ack/data_rdy channel between three tilemap VRAM readers (16-bit) and three GFX ROM readers (32-bit).
- Adds per-slot region offsets and a one-entry address/data cache per slot, so repeated reads of the same address return without an SDRAM access.
- Sits between jtcps1_video and the SDRAM controller.

Parameters:
- VRAM_OFFSET, 22'h32_0000, word offset added to VRAM slot addresses.
- GFX_OFFSET, 22'h10_0000, word offset added to ROM slot addresses.
- TIMEOUT, 64, max cycles in WAIT_DATA before abort (6-bit counter).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset (codebase rst stem, active-low)
- downloading  in  1  ROM download active; blocks grants, clears caches
- vram_cs  in  3  per-VRAM-slot request (slot0..2)
- vram_addr  in  3x18  word addresses, packed {s2,s1,s0}
- vram_data  out  3x16  cached data per slot
- vram_ok  out  3  data valid for current address
- rom_cs  in  3  per-ROM-slot request (slot3..5)
- rom_addr  in  3x22  word addresses, packed
- rom_data  out  3x32  cached data per slot
- rom_ok  out  3  data valid for current address
- sdram_req  out  1  request to controller
- sdram_ack  in  1  controller accepted request
- sdram_addr  out  22  word address = offset + slot address
- data_rdy  in  1  read data valid strobe
- data_read  in  32  {word[addr+1], word[addr]}
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All cache valid bits cleared; all data outputs 0.
  - sdram_req=0, sdram_addr=0, timeout_err=0.
  - FSM in IDLE; round-robin pointer at slot0.
- Hit, per slot: ok = cs && valid && (addr == cached_addr). Combinational, zero latency; no SDRAM access is issued.
- Pending, per slot: cs && !hit.
- FSM IDLE:
  - Grant when downloading=0 and any slot is pending.
  - Selection is round-robin, searching from slot after last grant, order 0..5, wrapping.
  - On grant: latch slot index and requested address. sdram_addr <= offset + zero-extended addr (22-bit sum, overflow wraps). sdram_req <= 1. Go to WAIT_ACK.
  - Grant issues the cycle after the pending condition is seen.
- FSM WAIT_ACK:
  - Hold sdram_req and sdram_addr stable until sdram_ack=1.
  - The next edge drops sdram_req and enters WAIT_DATA.
- FSM WAIT_DATA:
  - On data_rdy=1: store data_read (VRAM slots take [15:0], ROM slots take [31:0]) and the latched address into that slot's cache. Set valid. Go to IDLE.
  - ok then rises the cycle after data_rdy if cs is still high and addr is unchanged.
- Minimum miss latency: cs seen -> req 1 cycle, plus controller ack/data time, plus 1 cycle to ok.
- Address change mid-fetch: the cache still stores under the latched address. ok stays low and the slot re-pends afterwards.
- cs dropped mid-fetch: the fetch completes and is cached. It is not cancelled.
- data_rdy in IDLE or WAIT_ACK: ignored.
- sdram_ack in IDLE: ignored.
- Timeout: counter runs in WAIT_DATA. On reaching TIMEOUT-1 without data_rdy, return to IDLE with no cache update and set timeout_err. timeout_err clears only on reset.
- downloading=1:
  - Cache valid bits clear every cycle while high; all ok=0.
  - An in-flight transaction finishes normally but is not cached.
  - No new grants until downloading=0.
- Simultaneous data_rdy and new pending slots: store first. The new grant happens the following cycle from IDLE.
- Only one outstanding transaction at any time.

Optional Feature:
- Macro JTCPS1_ARB_ROMPRIO_EN.
- Defined:
  - ROM slots 3..5 strictly outrank VRAM slots 0..2.
  - Round-robin applies only within each group.
  - VRAM is granted only when no ROM slot is pending.
- Undefined: single six-slot round-robin as above.

Test Plan:
- Reset: rst_n=0 for 3 clks -> all ok=0, sdram_req=0, data outputs 0, timeout_err=0.
- Miss then hit, VRAM:
  - vram_cs[0]=1, addr 18'h00100, controller acks 1 clk after req and returns data_rdy with 32'hBEEF_1234 3 clks later.
  - sdram_addr = 22'h32_0100; vram_data[0]=16'h1234; vram_ok[0] rises next clk.
  - Re-asserting the same address gives ok in the same cycle with no new sdram_req.
- Round-robin:
  - All six cs high, distinct addrs, fixed 4-clk controller.
  - Grant order 0,1,2,3,4,5.
  - Then rom_addr[slot4] changes and vram_addr[slot1] changes together -> next grants slot1 then slot4.
- ROM path:
  - rom_cs[2]=1, addr 22'h00_0040, data 32'hCAFE_F00D.
  - sdram_addr = 22'h10_0040; rom_data[slot5]=32'hCAFE_F00D; rom_ok[2]=1.
- Timeout: ack given, data_rdy withheld -> after 64 clks FSM returns to IDLE and timeout_err=1. The slot re-requests.
- downloading:
  - Assert during WAIT_DATA -> data is not cached, all ok=0, no req while high.
  - Deassert -> the pending slot is re-fetched.
  - With JTCPS1_ARB_ROMPRIO_EN: vram_cs[0] and rom_cs[0] pending together -> ROM granted first.
